// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller.
// Holds the state encodings and the menu option codes.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_PIN      = 3'b001,
        ST_MENU     = 3'b010,
        ST_BALANCE  = 3'b011,
        ST_WITHDRAW = 3'b100,
        ST_DEPOSIT  = 3'b101,
        ST_DISPENSE = 3'b110,
        ST_EJECT    = 3'b111
    } state_e;

    // Menu option code, {O2,O1}
    typedef enum logic [1:0] {
        OPT_BAL  = 2'b00,
        OPT_WDR  = 2'b01,
        OPT_DEP  = 2'b10,
        OPT_EXIT = 2'b11
    } opt_e;

    localparam int unsigned TRY_W = 3;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Card-session bus between the ATM front panel / dispenser and the controller.
// master: drives card/keypad/dispenser inputs, observes session outputs.
// slave : the controller side.
interface atm_session_ctrl_if #(
    parameter int unsigned BAL_W = 16
);
    logic             C;
    logic             B;
    logic             E;
    logic             V;
    logic             O2;
    logic             O1;
    logic [BAL_W-1:0] AMT;
    logic             DISP_ACK;
    logic [2:0]       S;
    logic [BAL_W-1:0] BAL_OUT;
    logic             DISP_REQ;
    logic [BAL_W-1:0] DISP_AMT;
    logic             EJECT;
    logic             RETAIN;
    logic             ERR;

    modport master (
        output C, B, E, V, O2, O1, AMT, DISP_ACK,
        input  S, BAL_OUT, DISP_REQ, DISP_AMT, EJECT, RETAIN, ERR
    );

    modport slave (
        input  C, B, E, V, O2, O1, AMT, DISP_ACK,
        output S, BAL_OUT, DISP_REQ, DISP_AMT, EJECT, RETAIN, ERR
    );
endinterface

// File: rtl/atm_timeout_ctr.sv
// Inactivity counter: counts up while not cleared, saturates at CYC-1.
// Ports: clk_i, rst_ni (async active-low), clr_i (synchronous clear),
//        tc_o (registered, high while the count equals CYC-1).
module atm_timeout_ctr #(
    parameter int unsigned CYC = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tc_o
);
    localparam int unsigned CW = $clog2(CYC);
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tc_q;

    // Next count: clear wins, otherwise increment up to LAST and hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // tc is registered alongside the count so it tracks cnt_q == LAST
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == LAST);
        end
    end

    assign tc_o = tc_q;
endmodule

// File: rtl/atm_session_ctrl.sv
// ATM card-session controller: state register, PIN-retry counter, balance
// register, dispenser request/ack and inactivity timeout.
// Ports: CLK, RST_N (async active-low), bus (slave side of the session bus:
//        card/keypad/dispenser inputs in; S, BAL_OUT, DISP_REQ, DISP_AMT,
//        EJECT, RETAIN, ERR out, all registered).
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned INIT_BAL    = 100
) (
    input  logic                CLK,
    input  logic                RST_N,
    atm_session_ctrl_if.slave   bus
);
    state_e           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic             retain_q, retain_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic [BAL_W-1:0] disp_amt_q, disp_amt_d;
    logic             err_q, err_d;
    logic             eject_q, eject_d;
    logic             disp_req_q, disp_req_d;
    logic [BAL_W:0]   dep_sum;
    logic             timed_c;
    logic             tmo_tc;
    logic             tmo_clr_c;

    assign timed_c   = (state_q inside {ST_PIN, ST_MENU, ST_BALANCE,
                                        ST_WITHDRAW, ST_DEPOSIT});
    assign tries_inc = tries_q + TRY_W'(1);
    assign dep_sum   = {1'b0, bal_q} + {1'b0, bus.AMT};
    // Timer restarts on any strobe, any state change, and outside timed states
    assign tmo_clr_c = !timed_c || bus.B || bus.E || (state_d != state_q);

    atm_timeout_ctr #(.CYC(TIMEOUT_CYC)) u_tmo (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .clr_i  (tmo_clr_c),
        .tc_o   (tmo_tc)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        retain_d   = retain_q;
        bal_d      = bal_q;
        disp_amt_d = disp_amt_q;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.C) begin
                    state_d  = ST_PIN;
                    tries_d  = '0;
                    retain_d = 1'b0;
                end
            end
            ST_PIN: begin
                if (bus.B) begin
                    state_d = ST_EJECT;
                end else if (bus.E) begin
                    if (bus.V) begin
                        state_d = ST_MENU;
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == TRY_W'(MAX_TRIES)) begin
                            state_d  = ST_EJECT;
                            retain_d = 1'b1;
                        end
                    end
                end
            end
            ST_MENU: begin
                if (bus.B) begin
                    state_d = ST_EJECT;
                end else if (bus.E) begin
                    unique case (opt_e'({bus.O2, bus.O1}))
                        OPT_BAL:  state_d = ST_BALANCE;
                        OPT_WDR:  state_d = ST_WITHDRAW;
                        OPT_DEP:  state_d = ST_DEPOSIT;
                        OPT_EXIT: state_d = ST_EJECT;
                    endcase
                end
            end
            ST_BALANCE: begin
                if (bus.B || bus.E) begin
                    state_d = ST_MENU;
                end
            end
            ST_WITHDRAW: begin
                if (bus.B) begin
                    state_d = ST_MENU;
                end else if (bus.E) begin
                    if ((bus.AMT == '0) || (bus.AMT > bal_q)) begin
                        err_d = 1'b1;
                    end else begin
                        disp_amt_d = bus.AMT;
                        state_d    = ST_DISPENSE;
                    end
                end
            end
            ST_DEPOSIT: begin
                if (bus.B) begin
                    state_d = ST_MENU;
                end else if (bus.E) begin
                    bal_d   = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
                    state_d = ST_MENU;
                end
            end
            ST_DISPENSE: begin
                // Keypad and timeout are deliberately ignored until the ack
                if (bus.DISP_ACK) begin
                    bal_d   = (disp_amt_q > bal_q) ? '0 : (bal_q - disp_amt_q);
                    state_d = ST_MENU;
                end
            end
            ST_EJECT: begin
                if (!bus.C) begin
                    state_d  = ST_IDLE;
                    retain_d = 1'b0;
                end
            end
        endcase

        // Card pulled or inactivity both force an eject from timed states
        if (timed_c && (!bus.C || (tmo_tc && !bus.B && !bus.E))) begin
            state_d = ST_EJECT;
        end

        eject_d    = (state_d == ST_EJECT) && !retain_d;
        disp_req_d = (state_d == ST_DISPENSE);
    end

    // Session registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            tries_q    <= '0;
            retain_q   <= 1'b0;
            bal_q      <= BAL_W'(INIT_BAL);
            disp_amt_q <= '0;
            err_q      <= 1'b0;
            eject_q    <= 1'b0;
            disp_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            retain_q   <= retain_d;
            bal_q      <= bal_d;
            disp_amt_q <= disp_amt_d;
            err_q      <= err_d;
            eject_q    <= eject_d;
            disp_req_q <= disp_req_d;
        end
    end

    assign bus.S        = state_q;
    assign bus.BAL_OUT  = bal_q;
    assign bus.DISP_REQ = disp_req_q;
    assign bus.DISP_AMT = disp_amt_q;
    assign bus.EJECT    = eject_q;
    assign bus.RETAIN   = retain_q;
    assign bus.ERR      = err_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: each driven cycle pushes the
// expected outputs, which are popped and compared after the clock edge.
module tb_atm_session_ctrl;
    localparam int unsigned BAL_W = 16;

    typedef struct packed {
        logic [2:0]       s;
        logic [BAL_W-1:0] bal;
        logic             req;
        logic [BAL_W-1:0] amt;
        logic             ej;
        logic             ret;
        logic             err;
    } exp_t;

    logic CLK;
    logic RST_N;
    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step   = 0;

    atm_session_ctrl_if #(.BAL_W(BAL_W)) bus ();

    atm_session_ctrl #(
        .TIMEOUT_CYC (8),
        .MAX_TRIES   (3),
        .BAL_W       (BAL_W),
        .INIT_BAL    (100)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs now
    task automatic score();
        exp_t x;
        step++;
        x = sb_q.pop_front();
        chk($sformatf("s%0d.S", step),        32'(bus.S),        32'(x.s));
        chk($sformatf("s%0d.BAL", step),      32'(bus.BAL_OUT),  32'(x.bal));
        chk($sformatf("s%0d.DISP_REQ", step), 32'(bus.DISP_REQ), 32'(x.req));
        chk($sformatf("s%0d.DISP_AMT", step), 32'(bus.DISP_AMT), 32'(x.amt));
        chk($sformatf("s%0d.EJECT", step),    32'(bus.EJECT),    32'(x.ej));
        chk($sformatf("s%0d.RETAIN", step),   32'(bus.RETAIN),   32'(x.ret));
        chk($sformatf("s%0d.ERR", step),      32'(bus.ERR),      32'(x.err));
    endtask

    // One clock: push expectation, clock, compare, drop one-cycle strobes
    task automatic cyc(input logic [2:0] s, input logic [BAL_W-1:0] bal,
                       input logic req, input logic [BAL_W-1:0] damt,
                       input logic ej, input logic ret, input logic err);
        exp_t x;
        x = '{s: s, bal: bal, req: req, amt: damt, ej: ej, ret: ret, err: err};
        sb_q.push_back(x);
        @(posedge CLK);
        #1;
        score();
        bus.B        = 1'b0;
        bus.E        = 1'b0;
        bus.DISP_ACK = 1'b0;
    endtask

    task automatic set_opt(input logic [1:0] o);
        bus.O2 = o[1];
        bus.O1 = o[0];
    endtask

    initial begin
        exp_t x;
        RST_N        = 1'b0;
        bus.C        = 1'b0;
        bus.B        = 1'b0;
        bus.E        = 1'b0;
        bus.V        = 1'b0;
        bus.O2       = 1'b0;
        bus.O1       = 1'b0;
        bus.AMT      = '0;
        bus.DISP_ACK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        x = '{s: 3'd0, bal: 16'd100, req: 1'b0, amt: 16'd0, ej: 1'b0, ret: 1'b0, err: 1'b0};
        sb_q.push_back(x);
        score();
        RST_N = 1'b1;

        // Balance inquiry, then cancel from menu and pull card
        bus.C = 1'b1;                         cyc(3'd1, 16'd100, 0, 16'd0, 0, 0, 0);
        bus.E = 1'b1; bus.V = 1'b1;           cyc(3'd2, 16'd100, 0, 16'd0, 0, 0, 0);
        bus.E = 1'b1; set_opt(2'b00);         cyc(3'd3, 16'd100, 0, 16'd0, 0, 0, 0);
        bus.E = 1'b1;                         cyc(3'd2, 16'd100, 0, 16'd0, 0, 0, 0);
        bus.B = 1'b1;                         cyc(3'd7, 16'd100, 0, 16'd0, 1, 0, 0);
        bus.C = 1'b0;                         cyc(3'd0, 16'd100, 0, 16'd0, 0, 0, 0);

        // Withdraw 40 with a late ack, then rejected amounts
        bus.C = 1'b1;                         cyc(3'd1, 16'd100, 0, 16'd0, 0, 0, 0);
        bus.E = 1'b1; bus.V = 1'b1;           cyc(3'd2, 16'd100, 0, 16'd0, 0, 0, 0);
        bus.E = 1'b1; set_opt(2'b01);         cyc(3'd4, 16'd100, 0, 16'd0, 0, 0, 0);
        bus.E = 1'b1; bus.AMT = 16'd40;       cyc(3'd6, 16'd100, 1, 16'd40, 0, 0, 0);
        bus.B = 1'b1;                         cyc(3'd6, 16'd100, 1, 16'd40, 0, 0, 0);
        repeat (3)                            cyc(3'd6, 16'd100, 1, 16'd40, 0, 0, 0);
        bus.DISP_ACK = 1'b1;                  cyc(3'd2, 16'd60,  0, 16'd40, 0, 0, 0);
        bus.E = 1'b1; set_opt(2'b01);         cyc(3'd4, 16'd60,  0, 16'd40, 0, 0, 0);
        bus.E = 1'b1; bus.AMT = 16'd61;       cyc(3'd4, 16'd60,  0, 16'd40, 0, 0, 1);
                                              cyc(3'd4, 16'd60,  0, 16'd40, 0, 0, 0);
        bus.E = 1'b1; bus.AMT = 16'd0;        cyc(3'd4, 16'd60,  0, 16'd40, 0, 0, 1);
        // Exact balance accepted, ack in first dispense cycle
        bus.E = 1'b1; bus.AMT = 16'd60;       cyc(3'd6, 16'd60,  1, 16'd60, 0, 0, 0);
        bus.DISP_ACK = 1'b1;                  cyc(3'd2, 16'd0,   0, 16'd60, 0, 0, 0);

        // Deposits: plain, saturating, zero
        bus.E = 1'b1; set_opt(2'b10);         cyc(3'd5, 16'd0,   0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.AMT = 16'd100;      cyc(3'd2, 16'd100, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; set_opt(2'b10);         cyc(3'd5, 16'd100, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.AMT = 16'hFFF0;     cyc(3'd2, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; set_opt(2'b10);         cyc(3'd5, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.AMT = 16'd0;        cyc(3'd2, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; set_opt(2'b11);         cyc(3'd7, 16'hFFFF, 0, 16'd60, 1, 0, 0);
        bus.C = 1'b0;                         cyc(3'd0, 16'hFFFF, 0, 16'd60, 0, 0, 0);

        // Three wrong PINs retain the card
        bus.C = 1'b1;                         cyc(3'd1, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.V = 1'b0;           cyc(3'd1, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1;                         cyc(3'd1, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1;                         cyc(3'd7, 16'hFFFF, 0, 16'd60, 0, 1, 0);
                                              cyc(3'd7, 16'hFFFF, 0, 16'd60, 0, 1, 0);
        bus.C = 1'b0;                         cyc(3'd0, 16'hFFFF, 0, 16'd60, 0, 0, 0);

        // Inactivity in menu: eject on the 8th idle cycle
        bus.C = 1'b1;                         cyc(3'd1, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.V = 1'b1;           cyc(3'd2, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        repeat (7)                            cyc(3'd2, 16'hFFFF, 0, 16'd60, 0, 0, 0);
                                              cyc(3'd7, 16'hFFFF, 0, 16'd60, 1, 0, 0);
        bus.C = 1'b0;                         cyc(3'd0, 16'hFFFF, 0, 16'd60, 0, 0, 0);

        // B and E together in PIN: B wins
        bus.C = 1'b1;                         cyc(3'd1, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.B = 1'b1; bus.E = 1'b1;           cyc(3'd7, 16'hFFFF, 0, 16'd60, 1, 0, 0);
        bus.C = 1'b0;                         cyc(3'd0, 16'hFFFF, 0, 16'd60, 0, 0, 0);

        // Card pulled in menu
        bus.C = 1'b1;                         cyc(3'd1, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.V = 1'b1;           cyc(3'd2, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.C = 1'b0;                         cyc(3'd7, 16'hFFFF, 0, 16'd60, 1, 0, 0);
                                              cyc(3'd0, 16'hFFFF, 0, 16'd60, 0, 0, 0);

        // Async reset in the middle of a dispense
        bus.C = 1'b1;                         cyc(3'd1, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.V = 1'b1;           cyc(3'd2, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; set_opt(2'b01);         cyc(3'd4, 16'hFFFF, 0, 16'd60, 0, 0, 0);
        bus.E = 1'b1; bus.AMT = 16'd5;        cyc(3'd6, 16'hFFFF, 1, 16'd5,  0, 0, 0);
                                              cyc(3'd6, 16'hFFFF, 1, 16'd5,  0, 0, 0);
        #2;
        RST_N = 1'b0;
        #1;
        x = '{s: 3'd0, bal: 16'd100, req: 1'b0, amt: 16'd0, ej: 1'b0, ret: 1'b0, err: 1'b0};
        sb_q.push_back(x);
        score();
        bus.C = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
                                              cyc(3'd0, 16'd100, 0, 16'd0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
